// File: rtl/gen_scan_reader_pkg.sv
// gen_scan_reader_pkg
// Shared definitions for the Game-of-Life generation scanner:
//   ADDR_WIDTH  - width of board row/column addresses
//   COUNT_W     - width of the live-neighbour count (0..8)
//   K_W         - width of the 3x3 window read index (0..8)
//   scan_state_t- scanner FSM state encodings
//   life_rule   - next-generation value from self and neighbour count
package gen_scan_reader_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int COUNT_W    = 4;
   localparam int K_W        = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      EMIT  = 2'd3
   } scan_state_t;

   // Birth on exactly 3 neighbours, survival on 2 or 3.
   function automatic logic life_rule(input logic self_val, input logic [COUNT_W-1:0] cnt);
      return (cnt == COUNT_W'(3)) | (self_val & (cnt == COUNT_W'(2)));
   endfunction

endpackage

// File: rtl/gen_scan_reader_nbr_addr_gen.sv
// nbr_addr_gen
// Combinational toroidal neighbour address generator.
// Ports:
//   cen_r, cen_c  - centre cell row/column
//   k             - window index: 0 self, 1..8 neighbours NW,N,NE,W,E,SW,S,SE
//   nbr_r, nbr_c  - wrapped row/column of the addressed cell
module nbr_addr_gen
   import gen_scan_reader_pkg::*;
#(
   parameter int MAP_WIDTH  = 8,
   parameter int MAP_HEIGHT = 8
) (
   input  logic [ADDR_WIDTH-1:0] cen_r,
   input  logic [ADDR_WIDTH-1:0] cen_c,
   input  logic [K_W-1:0]        k,
   output logic [ADDR_WIDTH-1:0] nbr_r,
   output logic [ADDR_WIDTH-1:0] nbr_c
);

   localparam logic [ADDR_WIDTH-1:0] LAST_R = ADDR_WIDTH'(MAP_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(MAP_WIDTH - 1);

   logic [ADDR_WIDTH-1:0] up_r, dn_r, lf_c, rt_c;

   // Wrap by comparison rather than modulo: centre is always in range.
   assign up_r = (cen_r == '0)     ? LAST_R : cen_r - ADDR_WIDTH'(1);
   assign dn_r = (cen_r == LAST_R) ? '0     : cen_r + ADDR_WIDTH'(1);
   assign lf_c = (cen_c == '0)     ? LAST_C : cen_c - ADDR_WIDTH'(1);
   assign rt_c = (cen_c == LAST_C) ? '0     : cen_c + ADDR_WIDTH'(1);

   always_comb begin
      nbr_r = cen_r;
      nbr_c = cen_c;
      case (k)
         4'd1: begin nbr_r = up_r; nbr_c = lf_c; end
         4'd2: begin nbr_r = up_r;               end
         4'd3: begin nbr_r = up_r; nbr_c = rt_c; end
         4'd4: begin               nbr_c = lf_c; end
         4'd5: begin               nbr_c = rt_c; end
         4'd6: begin nbr_r = dn_r; nbr_c = lf_c; end
         4'd7: begin nbr_r = dn_r;               end
         4'd8: begin nbr_r = dn_r; nbr_c = rt_c; end
         default: ;
      endcase
   end

endmodule

// File: rtl/gen_scan_reader.sv
// gen_scan_reader
// Scans the whole cell board once per start request, reading each cell's
// 3x3 toroidal window and emitting the next-generation value (11 cycles/cell).
// Ports:
//   clk, rst (sync, active-low)
//   start, mode      - step request; mode 1 = run, 0 = edit (aborts a scan)
//   rAddrR, rAddrC   - board read address (0 when not reading)
//   read_data        - board data, one cycle after its address
//   out_valid, oAddrR, oAddrC, out_data - computed cell result pulse
//   busy, done       - scan in progress / last cell emitted
module gen_scan_reader
   import gen_scan_reader_pkg::*;
#(
   parameter int MAP_WIDTH  = 8,
   parameter int MAP_HEIGHT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   output logic [ADDR_WIDTH-1:0] rAddrR,
   output logic [ADDR_WIDTH-1:0] rAddrC,
   input  logic                  read_data,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] oAddrR,
   output logic [ADDR_WIDTH-1:0] oAddrC,
   output logic                  out_data,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_R = ADDR_WIDTH'(MAP_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(MAP_WIDTH - 1);
   localparam logic [K_W-1:0]        K_LAST = K_W'(8);

   scan_state_t           state;
   logic [ADDR_WIDTH-1:0] cen_r, cen_c;
   logic [K_W-1:0]        k;
   logic [COUNT_W-1:0]    count;
   logic                  self_val;
   logic [ADDR_WIDTH-1:0] nbr_r, nbr_c;
   logic                  last_cell, emit;

   nbr_addr_gen #(
      .MAP_WIDTH  (MAP_WIDTH),
      .MAP_HEIGHT (MAP_HEIGHT)
   ) u_nbr (
      .cen_r (cen_r),
      .cen_c (cen_c),
      .k     (k),
      .nbr_r (nbr_r),
      .nbr_c (nbr_c)
   );

   assign last_cell = (cen_r == LAST_R) && (cen_c == LAST_C);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cen_r    <= '0;
         cen_c    <= '0;
         k        <= '0;
         count    <= '0;
         self_val <= 1'b0;
      end else if (state != IDLE && !mode) begin
         // Leaving run mode abandons the scan; the next start restarts at (0,0).
         state    <= IDLE;
         k        <= '0;
         count    <= '0;
         self_val <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && mode) begin
                  state    <= READ;
                  cen_r    <= '0;
                  cen_c    <= '0;
                  k        <= '0;
                  count    <= '0;
                  self_val <= 1'b0;
               end
            end
            READ: begin
               // read_data belongs to the address driven one cycle earlier (k-1).
               if (k == K_W'(1))
                  self_val <= read_data;
               else if (k >= K_W'(2))
                  count <= count + COUNT_W'(read_data);
               if (k == K_LAST)
                  state <= DRAIN;
               else
                  k <= k + K_W'(1);
            end
            DRAIN: begin
               count <= count + COUNT_W'(read_data);
               state <= EMIT;
            end
            EMIT: begin
               k        <= '0;
               count    <= '0;
               self_val <= 1'b0;
               if (last_cell) begin
                  state <= IDLE;
                  cen_r <= '0;
                  cen_c <= '0;
               end else begin
                  state <= READ;
                  if (cen_c == LAST_C) begin
                     cen_c <= '0;
                     cen_r <= cen_r + ADDR_WIDTH'(1);
                  end else begin
                     cen_c <= cen_c + ADDR_WIDTH'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A cycle with mode low is being aborted, so its result is suppressed.
   assign emit      = (state == EMIT) && mode;
   assign busy      = (state != IDLE);
   assign rAddrR    = (state == READ) ? nbr_r : '0;
   assign rAddrC    = (state == READ) ? nbr_c : '0;
   assign out_valid = emit;
   assign oAddrR    = emit ? cen_r : '0;
   assign oAddrC    = emit ? cen_c : '0;
   assign out_data  = emit & life_rule(self_val, count);
   assign done      = emit & last_cell;

endmodule

// File: tb/tb_gen_scan_reader.sv
module tb_gen_scan_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       mode;
   logic [7:0] rAddrR, rAddrC, oAddrR, oAddrC;
   logic       read_data;
   logic       out_valid, out_data, busy, done;

   int vectors = 0;
   int miscompares = 0;

   logic board [0:7][0:7];
   logic live  [0:7][0:7];

   int n_valid, n_done, done_cyc, first_r, first_c;
   int addr_r [0:8];
   int addr_c [0:8];

   // Expected read order around centre (0,0).
   int exp_r [0:8] = '{0, 7, 7, 7, 0, 0, 1, 1, 1};
   int exp_c [0:8] = '{0, 7, 0, 1, 7, 1, 7, 0, 1};

   always #5 clk = ~clk;

   gen_scan_reader #(.MAP_WIDTH(8), .MAP_HEIGHT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .rAddrR    (rAddrR),
      .rAddrC    (rAddrC),
      .read_data (read_data),
      .out_valid (out_valid),
      .oAddrR    (oAddrR),
      .oAddrC    (oAddrC),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   // Board memory with one-cycle read latency.
   always_ff @(posedge clk) read_data <= board[rAddrR[2:0]][rAddrC[2:0]];

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_board();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            board[r][c] = 1'b0;
   endtask

   function automatic int live_total();
      int n = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (live[r][c]) n++;
      return n;
   endfunction

   // Pulse start, then observe max_cyc cycles. Cycle 1 is the first cycle after
   // the start edge. again_at / drop_at / rst_at inject events at that cycle.
   task automatic run_scan(input int max_cyc, input int again_at, input int drop_at, input int rst_at);
      n_valid = 0; n_done = 0; done_cyc = 0; first_r = -1; first_c = -1;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            live[r][c] = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (i <= 9) begin
            addr_r[i-1] = int'(rAddrR);
            addr_c[i-1] = int'(rAddrC);
         end
         if (out_valid) begin
            if (n_valid == 0) begin
               first_r = int'(oAddrR);
               first_c = int'(oAddrC);
            end
            n_valid++;
            if (out_data) live[oAddrR[2:0]][oAddrC[2:0]] = 1'b1;
         end
         if (done) begin
            n_done++;
            done_cyc = i;
         end
         if (i == drop_at + 1 || i == rst_at + 1) begin
            chk("abort_busy", int'(busy), 0);
            chk("abort_valid", int'(out_valid), 0);
            chk("abort_raddr_r", int'(rAddrR), 0);
            chk("abort_raddr_c", int'(rAddrC), 0);
         end
         start = (i == again_at);
         if (i == drop_at) mode = 1'b0;
         rst = (i == rst_at) ? 1'b0 : 1'b1;
      end
      start = 1'b0; mode = 1'b1; rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = 1'b0;
      clear_board();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_raddr_r", int'(rAddrR), 0);
      chk("rst_raddr_c", int'(rAddrC), 0);
      rst = 1'b1;

      // Blinker: horizontal bar becomes vertical.
      board[3][2] = 1'b1; board[3][3] = 1'b1; board[3][4] = 1'b1;
      run_scan(720, -1, -1, -1);
      for (int j = 0; j < 9; j++) begin
         chk($sformatf("rd_seq_r%0d", j), addr_r[j], exp_r[j]);
         chk($sformatf("rd_seq_c%0d", j), addr_c[j], exp_c[j]);
      end
      chk("blink_first_r", first_r, 0);
      chk("blink_first_c", first_c, 0);
      chk("blink_valids", n_valid, 64);
      chk("blink_dones", n_done, 1);
      chk("blink_done_cyc", done_cyc, 704);
      chk("blink_2_3", int'(live[2][3]), 1);
      chk("blink_3_3", int'(live[3][3]), 1);
      chk("blink_4_3", int'(live[4][3]), 1);
      chk("blink_live", live_total(), 3);
      chk("idle_busy", int'(busy), 0);

      // Second start mid-scan is ignored.
      run_scan(720, 100, -1, -1);
      chk("again_valids", n_valid, 64);
      chk("again_dones", n_done, 1);
      chk("again_done_cyc", done_cyc, 704);
      chk("again_live", live_total(), 3);

      // Toroidal wrap: three corners form a wrapped 2x2 block.
      clear_board();
      board[0][0] = 1'b1; board[0][7] = 1'b1; board[7][0] = 1'b1;
      run_scan(720, -1, -1, -1);
      chk("wrap_birth_7_7", int'(live[7][7]), 1);
      chk("wrap_survive_0_0", int'(live[0][0]), 1);
      chk("wrap_live", live_total(), 4);

      // Start in edit mode does nothing.
      @(negedge clk);
      start = 1'b1; mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("edit_start_busy", int'(busy), 0);
      @(negedge clk);
      chk("edit_start_busy2", int'(busy), 0);
      mode = 1'b1;

      // Mode falls during cell 2: abort, no done.
      run_scan(60, -1, 30, -1);
      chk("drop_valids", n_valid, 2);
      chk("drop_dones", n_done, 0);

      // Reset during cell 20 (cycles 221..231).
      run_scan(240, -1, -1, 225);
      chk("rst_mid_valids", n_valid, 20);
      chk("rst_mid_dones", n_done, 0);

      // Next scan after reset begins at (0,0).
      run_scan(15, -1, -1, -1);
      chk("post_rst_first_r", first_r, 0);
      chk("post_rst_first_c", first_c, 0);
      chk("post_rst_valids", n_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
